// File: rtl/seg7_bus_monitor.sv
// Reader for a multiplexed active-low 7-segment bus: syncs, debounces, decodes to BCD per digit.
// Optional SEG7_MON_ERRCNT_EN adds a saturating err_count output.
module seg7_bus_monitor #(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [0:6]              seg_in,
    input  logic [NUM_DIGITS-1:0]   an_in,
    output logic [4*NUM_DIGITS-1:0] digits_out,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    update,
`ifdef SEG7_MON_ERRCNT_EN
    output logic                    err,
    output logic [7:0]              err_count
`else
    output logic                    err
`endif
);

    localparam int unsigned SW = 7 + NUM_DIGITS;
    localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {StWait, StStable, StLocked} state_e;

    state_e          state_q;
    logic [CW-1:0]   stab_cnt;
    logic [SW-1:0]   sync1_q, sync2_q, prev_q;
    logic [0:6]      s_seg;
    logic [NUM_DIGITS-1:0] s_an;
    logic [3:0]      dec_val;
    logic            dec_legal;
    logic            an_blank, an_onehot;
    logic [IW-1:0]   an_idx;
    logic            same, do_commit, commit_err, commit_wr;

    assign s_seg = sync2_q[SW-1 -: 7];
    assign s_an  = sync2_q[NUM_DIGITS-1:0];
    assign same  = (sync2_q == prev_q);

    always_comb begin
        dec_legal = 1'b1;
        dec_val   = 4'h0;
        case (s_seg)
            7'b0000001: dec_val = 4'd0;
            7'b1001111: dec_val = 4'd1;
            7'b0010010: dec_val = 4'd2;
            7'b0000110: dec_val = 4'd3;
            7'b1001100: dec_val = 4'd4;
            7'b0100100: dec_val = 4'd5;
            7'b0100000: dec_val = 4'd6;
            7'b0001111: dec_val = 4'd7;
            7'b0000000: dec_val = 4'd8;
            7'b0000100: dec_val = 4'd9;
            7'b1111111: dec_val = 4'hF;
            default:    dec_legal = 1'b0;
        endcase
    end

    always_comb begin
        an_blank  = &s_an;
        an_onehot = $onehot(~s_an);
        an_idx    = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!s_an[i]) an_idx = IW'(i);
        end
    end

    // Commit fires on the edge where the count would reach STABLE_CYCLES.
    always_comb begin
        do_commit = 1'b0;
        if (same) begin
            if (state_q == StWait && STABLE_CYCLES == 1) do_commit = 1'b1;
            if (state_q == StStable && stab_cnt >= CNT_LAST) do_commit = 1'b1;
        end
        commit_err = do_commit && !an_blank && (!an_onehot || !dec_legal);
        commit_wr  = do_commit && !an_blank && an_onehot && dec_legal;
    end

    // Sync flops reset to the idle bus (all segments and anodes off).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
            prev_q  <= '1;
        end else begin
            sync1_q <= {seg_in, an_in};
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StWait;
            stab_cnt    <= '0;
            digits_out  <= '0;
            digit_valid <= '0;
            update      <= 1'b0;
            err         <= 1'b0;
        end else begin
            update <= 1'b0;
            err    <= 1'b0;
            if (!same) begin
                state_q  <= StWait;
                stab_cnt <= '0;
            end else begin
                if (stab_cnt != CNT_MAX) stab_cnt <= stab_cnt + CW'(1);
                unique case (state_q)
                    StWait:   state_q <= (STABLE_CYCLES == 1) ? StLocked : StStable;
                    StStable: if (do_commit) state_q <= StLocked;
                    default:  state_q <= StLocked;
                endcase
            end
            if (commit_err) err <= 1'b1;
            if (commit_wr) begin
                digits_out[4*an_idx +: 4] <= dec_val;
                digit_valid[an_idx]       <= 1'b1;
                if (!digit_valid[an_idx] || digits_out[4*an_idx +: 4] != dec_val) update <= 1'b1;
            end
        end
    end

`ifdef SEG7_MON_ERRCNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= 8'h00;
        end else if (commit_err && err_count != 8'hFF) begin
            err_count <= err_count + 8'h01;
        end
    end
`endif

endmodule
